// File: rtl/fs_serial_sub.sv
// rtl/fs_serial_sub.sv - multi-cycle N-bit subtractor/adder, one CHUNK-bit slice per clock
module fs_serial_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_chain;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_ovf;
    logic             w_last;

    // Top bit of the CHUNK+1 wide result is the borrow (sub) or carry (add) out of the slice
    always_comb begin
        w_a_sl       = '0;
        w_b_sl       = '0;
        w_shadow_nxt = r_shadow;
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_sl = r_a[k*CHUNK +: CHUNK];
                w_b_sl = r_b[k*CHUNK +: CHUNK];
            end
        end
        if (r_mode)
            w_slice = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_chain};
        else
            w_slice = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{CHUNK{1'b0}}, r_chain};
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CW'(k))
                w_shadow_nxt[k*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
        end
    end

    assign w_last = (r_cnt == LAST);
    assign w_ovf  = r_mode ? ((r_a[MSB] == r_b[MSB]) && (w_shadow_nxt[MSB] != r_a[MSB]))
                           : ((r_a[MSB] != r_b[MSB]) && (w_shadow_nxt[MSB] != r_a[MSB]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_chain  <= 1'b0;
            r_shadow <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_shadow <= w_shadow_nxt;
                    r_chain  <= w_slice[CHUNK];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_d     <= w_shadow_nxt;
                        r_bout  <= w_slice[CHUNK];
                        r_ovf   <= w_ovf;
                    end
                end
                // IDLE and DONE both accept a new request; DONE gives back-to-back throughput
                default: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_chain <= bin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
